// File: rtl/seg7_pkg.sv
// Shared types and segment pattern constants for the seven-segment display reader.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Active-high segment patterns, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_D0    = 7'h3F;
  localparam logic [6:0] SEG_D1    = 7'h06;
  localparam logic [6:0] SEG_D2    = 7'h5B;
  localparam logic [6:0] SEG_D3    = 7'h4F;
  localparam logic [6:0] SEG_D4    = 7'h66;
  localparam logic [6:0] SEG_D5    = 7'h6D;
  localparam logic [6:0] SEG_D6    = 7'h7D;
  localparam logic [6:0] SEG_D7    = 7'h07;
  localparam logic [6:0] SEG_D8    = 7'h7F;
  localparam logic [6:0] SEG_D9    = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_digit_decode.sv
// Maps one seven-segment pattern to a BCD digit; blank reads as zero.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_D0, SEG_BLANK: digit = 4'd0;
      SEG_D1:            digit = 4'd1;
      SEG_D2:            digit = 4'd2;
      SEG_D3:            digit = 4'd3;
      SEG_D4:            digit = 4'd4;
      SEG_D5:            digit = 4'd5;
      SEG_D6:            digit = 4'd6;
      SEG_D7:            digit = 4'd7;
      SEG_D8:            digit = 4'd8;
      SEG_D9:            digit = 4'd9;
      default:           valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples a four-digit seven-segment display, waits for it to settle and
// presents each new reading as BCD and binary over a valid/ready handshake.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [6:0]  seg_0,
  input  logic [6:0]  seg_1,
  input  logic [6:0]  seg_2,
  input  logic [6:0]  seg_3,
  input  logic        done_in,
  input  logic        clr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_bcd,
  output logic [13:0] out_bin,
  output logic        err_invalid,
  output logic        overrun,
  output logic        done_pulse
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
         + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
  endfunction

  state_t      state, state_nx;
  logic [27:0] snap, snap_prev, last_captured;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  dig [4];
  logic [3:0]  dvld;
  logic        reached, changed, capture, set_inv, set_ovr;
  logic        done_r, done_rr;
  logic [15:0] bcd_snap;

  for (genvar i = 0; i < 4; i++) begin : g_dec
    seg7_digit_decode u_dec (
      .pattern (snap[7*i +: 7]),
      .digit   (dig[i]),
      .valid   (dvld[i])
    );
  end

  assign bcd_snap  = {dig[3], dig[2], dig[1], dig[0]};
  assign changed   = (snap != last_captured);
  assign out_valid = (state == ST_PRESENT);

  always_comb begin
    if (snap != snap_prev)  cnt_nx = 4'd0;
    else if (cnt >= STABLE_N) cnt_nx = STABLE_N;
    else                      cnt_nx = cnt + 4'd1;
  end

  // Act on the edge where the counter lands on STABLE_N so the reading appears
  // STABLE_CYCLES+2 cycles after the pattern first reaches the pins.
  assign reached = (cnt_nx == STABLE_N);

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    set_inv  = 1'b0;
    set_ovr  = 1'b0;
    case (state)
      ST_IDLE: if (changed) state_nx = ST_SETTLE;
      ST_SETTLE: begin
        if (reached) begin
          if (!changed) begin
            state_nx = ST_IDLE;
          end else if (&dvld) begin
            capture  = 1'b1;
            state_nx = ST_PRESENT;
          end else begin
            set_inv  = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_PRESENT: begin
        if (out_ready) state_nx = changed ? ST_SETTLE : ST_IDLE;
        else if (reached && changed) set_ovr = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      snap          <= '0;
      snap_prev     <= '0;
      cnt           <= '0;
      last_captured <= '0;
      out_bcd       <= '0;
      out_bin       <= '0;
      err_invalid   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state     <= state_nx;
      snap      <= {seg_3, seg_2, seg_1, seg_0};
      snap_prev <= snap;
      cnt       <= cnt_nx;
      if (capture) begin
        out_bcd <= bcd_snap;
        out_bin <= bcd_to_bin(bcd_snap);
      end
      // An invalid pattern is remembered so it is reported once, not re-read.
      if (capture || set_inv) last_captured <= snap;
      err_invalid <= set_inv | (err_invalid & ~clr);
      overrun     <= set_ovr | (overrun & ~clr);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_r     <= 1'b0;
      done_rr    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_r     <= done_in;
      done_rr    <= done_r;
      done_pulse <= done_r & ~done_rr;
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with a scoreboard of expected readings.
module tb_seg7_reader;

  localparam int SC = 4;
  localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F, P4 = 7'h66;
  localparam logic [6:0] P5 = 7'h6D, P6 = 7'h7D, P7 = 7'h07, P8 = 7'h7F, P9 = 7'h6F;
  localparam logic [6:0] PBAD = 7'h7E;

  logic        clk = 1'b0;
  logic        nrst, done_in, clr, out_ready;
  logic [6:0]  seg_0, seg_1, seg_2, seg_3;
  logic        out_valid, err_invalid, overrun, done_pulse;
  logic [15:0] out_bcd;
  logic [13:0] out_bin;

  typedef struct packed {
    logic [15:0] bcd;
    logic [13:0] bin;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  seg7_reader #(.STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .seg_0       (seg_0),
    .seg_1       (seg_1),
    .seg_2       (seg_2),
    .seg_3       (seg_3),
    .done_in     (done_in),
    .clr         (clr),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_bcd     (out_bcd),
    .out_bin     (out_bin),
    .err_invalid (err_invalid),
    .overrun     (overrun),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_seg(input logic [6:0] d3, d2, d1, d0);
    seg_3 = d3; seg_2 = d2; seg_1 = d1; seg_0 = d0;
  endtask

  task automatic push(input logic [15:0] b, input int v);
    exp_t e;
    e.bcd = b;
    e.bin = 14'(v);
    sbq.push_back(e);
  endtask

  task automatic wait_valid(input string tag, input int lim, output int k);
    int i;
    k = 0;
    i = 0;
    while (k == 0 && i < lim) begin
      step();
      i++;
      if (out_valid) k = i;
    end
    chk(tag, 32'(k != 0), 32'd1);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while ((sbq.size() != 0 || out_valid) && i < 60) begin
      step();
      i++;
    end
    chk(tag, 32'(sbq.size()), 32'd0);
  endtask

  // Every accepted reading is checked against the oldest expected one.
  always @(negedge clk) begin
    if (nrst && out_valid) begin
      valid_cnt++;
      if (out_ready) begin
        chk("rd_pending", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          chk("rd_bcd", 32'(out_bcd), 32'(mon_e.bcd));
          chk("rd_bin", 32'(out_bin), 32'(mon_e.bin));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, v0, pulses, pos;
    nrst = 1'b0; done_in = 1'b0; clr = 1'b0; out_ready = 1'b0;
    set_seg(7'h00, 7'h00, 7'h00, 7'h00);
    step(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'd0);
    chk("rst_bin", 32'(out_bin), 32'd0);
    chk("rst_err", 32'(err_invalid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);
    nrst = 1'b1;
    step(4);
    chk("idle_blank", 32'(valid_cnt), 32'd0);

    // Basic reading and latency
    out_ready = 1'b1;
    v0 = valid_cnt;
    push(16'h1234, 1234);
    set_seg(P1, P2, P3, P4);
    wait_valid("lat_timeout", 20, k);
    chk("latency", 32'(k), 32'(SC + 2));
    step(4);
    chk("one_pulse", 32'(valid_cnt - v0), 32'd1);
    drain("drain_1234");

    // Toggling digit never settles
    v0 = valid_cnt;
    for (int i = 0; i < 10; i++) begin
      seg_0 = (i % 2 == 1) ? P1 : P0;
      step(2);
    end
    chk("toggle_novalid", 32'(valid_cnt - v0), 32'd0);
    chk("toggle_noerr", 32'(err_invalid), 32'd0);
    push(16'h1231, 1231);
    drain("drain_1231");

    // Pending 9999, newer 0000 dropped, then wrap-around reading
    out_ready = 1'b0;
    push(16'h9999, 9999);
    set_seg(P9, P9, P9, P9);
    wait_valid("ovr_timeout", 20, k);
    set_seg(P0, P0, P0, P0);
    step(10);
    chk("ovr_hold_bcd", 32'(out_bcd), 32'h9999);
    chk("ovr_hold_bin", 32'(out_bin), 32'd9999);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    push(16'h0000, 0);
    out_ready = 1'b1;
    drain("drain_wrap");
    chk("ovr_sticky", 32'(overrun), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Invalid pattern flags an error and yields no reading
    v0 = valid_cnt;
    set_seg(P0, P0, PBAD, P0);
    step(12);
    chk("inv_flag", 32'(err_invalid), 32'd1);
    chk("inv_novalid", 32'(valid_cnt - v0), 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("inv_clr", 32'(err_invalid), 32'd0);
    push(16'h0080, 80);
    seg_1 = P8;
    drain("drain_0080");
    chk("p8_noerr", 32'(err_invalid), 32'd0);

    // done_in rising edge
    pulses = 0; pos = 0;
    done_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (done_pulse) begin
        pulses++;
        pos = i;
      end
    end
    chk("done_count", 32'(pulses), 32'd1);
    chk("done_pos", 32'(pos), 32'd2);
    done_in = 1'b0;
    step(3);

    // Reset while a reading is pending
    out_ready = 1'b0;
    set_seg(P5, P6, P7, P8);
    wait_valid("rstp_timeout", 20, k);
    chk("rstp_bcd", 32'(out_bcd), 32'h5678);
    chk("rstp_bin", 32'(out_bin), 32'd5678);
    #1 nrst = 1'b0;
    #1;
    chk("rstp_valid", 32'(out_valid), 32'd0);
    chk("rstp_bcd0", 32'(out_bcd), 32'd0);
    chk("rstp_bin0", 32'(out_bin), 32'd0);
    chk("rstp_err", 32'(err_invalid), 32'd0);
    chk("rstp_ovr", 32'(overrun), 32'd0);
    chk("rstp_done", 32'(done_pulse), 32'd0);
    #1 nrst = 1'b1;
    push(16'h5678, 5678);
    out_ready = 1'b1;
    drain("drain_reread");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
